// File: rtl/sintab_arb.sv
// sintab_arb: round-robin scheduler sharing one registered log-sine LUT
// (sintab) among NREQ FM operator requesters.
//
// Each requester offers a full-wave phase of asz+2 bits. The granted phase is
// folded to a quarter-wave address and registered onto tab_addr. The sign
// travels alongside in a two-stage pipeline that matches the LUT's one-cycle
// read. A lookup granted in cycle T therefore answers in cycle T+2.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   req        in   [NREQ]           per-requester lookup request (valid)
//   req_phase  in   [NREQ*(asz+2)]   packed phases, requester i at [i*(asz+2) +: asz+2]
//   ack        out  [NREQ]           one-hot combinational grant (ready)
//   tab_addr   out  [asz]            registered LUT address
//   tab_sine   in   [osz]            LUT registered output
//   rsp_valid  out                   one-cycle response strobe per lookup
//   rsp_id     out  [IDW]            requester owning the response
//   rsp_sine   out  [osz]            log-sine magnitude (tab_sine passthrough)
//   rsp_sign   out                   sign of the sine (phase MSB)
module sintab_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int asz  = 8,
    parameter int osz  = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*(asz+2)-1:0]  req_phase,
    output logic [NREQ-1:0]          ack,
    output logic [asz-1:0]           tab_addr,
    input  logic [osz-1:0]           tab_sine,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [osz-1:0]           rsp_sine,
    output logic                     rsp_sign
);

    localparam int PW = asz + 2;

    logic [IDW-1:0]  r_ptr;
    logic [asz-1:0]  r_tab_addr;
    logic            r_s1_valid;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s1_sign;
    logic            r_s2_valid;
    logic [IDW-1:0]  r_s2_id;
    logic            r_s2_sign;

    logic [NREQ-1:0] w_ack;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_found;
    logic            w_xfer;
    logic [PW-1:0]   w_phase;
    logic [asz-1:0]  w_fold;

    // Round-robin search: start one past the last winner and wrap modulo
    // NREQ, so the previous winner has the lowest priority next time.
    always_comb begin
        // NOTE: every variable gets a default before the search so no path
        // through this block can hold an old value and infer a latch.
        w_ack     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int j = 1; j <= NREQ; j++) begin
            if (!w_found && req[IDW'((int'(r_ptr) + j) % NREQ)]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'((int'(r_ptr) + j) % NREQ);
            end
        end
        // No grant may be issued while reset is held.
        if (w_found && reset_n) begin
            w_ack[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer = |w_ack;

    // Phase mux driven by the one-hot grant; constant slice bases only.
    always_comb begin
        w_phase = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ack[i]) begin
                w_phase = req_phase[i*PW +: PW];
            end
        end
    end

    // Quarter-wave fold: odd quadrants run the table backwards.
    assign w_fold = w_phase[asz] ? ~w_phase[asz-1:0] : w_phase[asz-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the whole pipeline is reset, not just the valids, so
            // rsp_id/rsp_sign read as zero after reset rather than stale data.
            r_ptr      <= IDW'(NREQ - 1);
            r_tab_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_sign  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_sign  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, making the two stages a true pipeline.
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr      <= w_gnt_idx;
                r_tab_addr <= w_fold;
                r_s1_id    <= w_gnt_idx;
                r_s1_sign  <= w_phase[asz+1];
            end
            // Second stage mirrors the LUT's own read register.
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_sign  <= r_s1_sign;
        end
    end

    assign ack       = w_ack;
    assign tab_addr  = r_tab_addr;
    assign rsp_valid = r_s2_valid;
    assign rsp_id    = r_s2_id;
    assign rsp_sign  = r_s2_sign;
    assign rsp_sine  = tab_sine;

endmodule

// File: tb/tb_sintab_arb.sv
// tb_sintab_arb: directed and randomized bench for sintab_arb. A queue-based
// reference model predicts grants, the folded address and each response;
// the LUT is modelled as a register returning addr + 0x100.
module tb_sintab_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int ASZ  = 8;
    localparam int OSZ  = 12;
    localparam int PW   = ASZ + 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*PW-1:0]  req_phase = '0;
    logic [NREQ-1:0]     ack;
    logic [ASZ-1:0]      tab_addr;
    logic [OSZ-1:0]      tab_sine;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [OSZ-1:0]      rsp_sine;
    logic                rsp_sign;

    always #5 clk = ~clk;

    // sintab stand-in: one-cycle registered read returning addr + 0x100.
    always @(posedge clk) tab_sine <= {4'h0, tab_addr} + 12'h100;

    sintab_arb #(.NREQ(NREQ), .IDW(IDW), .asz(ASZ), .osz(OSZ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_phase (req_phase),
        .ack       (ack),
        .tab_addr  (tab_addr),
        .tab_sine  (tab_sine),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sine  (rsp_sine),
        .rsp_sign  (rsp_sign)
    );

    typedef struct {
        int             due;
        int             id;
        logic [ASZ-1:0] addr;
        logic           sign;
    } rsp_t;

    rsp_t           m_q[$];
    int             m_ptr;
    logic [ASZ-1:0] m_addr;
    int             cyc;
    int             n_tests;
    int             n_fail;
    int             m_ack_cnt[NREQ];
    int             d_ack_cnt[NREQ];
    int             d_rsp_cnt[NREQ];
    logic [PW-1:0]  ph[NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rotating priority: first requester after the last winner, with wrap.
    function automatic int model_arb(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Quarter-wave mirror expressed as arithmetic on the table index.
    function automatic logic [ASZ-1:0] fold(input logic [PW-1:0] p);
        int lo;
        lo = int'(p[ASZ-1:0]);
        if (p[ASZ]) lo = (2**ASZ - 1) - lo;
        return ASZ'(lo);
    endfunction

    task automatic apply();
        for (int i = 0; i < NREQ; i++) req_phase[i*PW +: PW] = ph[i];
    endtask

    task automatic model_reset();
        m_ptr  = NREQ - 1;
        m_addr = '0;
        m_q.delete();
    endtask

    // One clock cycle: inputs already set just after the rising edge; DUT
    // is sampled on the falling edge, then the model advances on the edge.
    task automatic run_cycle(output logic [NREQ-1:0] obs_ack, output logic [NREQ-1:0] exp_ack);
        int   g;
        rsp_t r;
        apply();
        @(negedge clk);
        g = model_arb(req, m_ptr);
        exp_ack = (g >= 0) ? (NREQ'(1) << g) : '0;
        obs_ack = ack;
        check("ack", 32'(ack), 32'(exp_ack));
        check("tab_addr", 32'(tab_addr), 32'(m_addr));
        for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) d_ack_cnt[i]++;
        if (rsp_valid === 1'b1) d_rsp_cnt[rsp_id]++;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            r = m_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(r.id));
            check("rsp_sign", 32'(rsp_sign), 32'(r.sign));
            check("rsp_sine", 32'(rsp_sine), 32'(r.addr) + 32'h100);
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        if (g >= 0) begin
            r.due  = cyc + 2;
            r.id   = g;
            r.addr = fold(ph[g]);
            r.sign = ph[g][PW-1];
            m_q.push_back(r);
            m_ptr  = g;
            m_addr = r.addr;
            m_ack_cnt[g]++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        apply();
        @(negedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] oa;
        logic [NREQ-1:0] ea;
        logic [NREQ-1:0] last_ea;
        logic [PW-1:0]   t1_ph[4];
        logic [ASZ-1:0]  t1_addr[4];

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < NREQ; i++) begin
            ph[i] = '0;
            m_ack_cnt[i] = 0;
            d_ack_cnt[i] = 0;
            d_rsp_cnt[i] = 0;
        end
        model_reset();

        // Reset state, with every request high to prove ack is gated.
        req = '1;
        apply();
        #1 reset_n = 1'b0;
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tab_addr", 32'(tab_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sign", 32'(rsp_sign), 32'd0);
        req = '0;
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, one phase per quadrant on consecutive cycles.
        t1_ph   = '{10'h05A, 10'h15A, 10'h25A, 10'h35A};
        t1_addr = '{8'h5A, 8'hA5, 8'h5A, 8'hA5};
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            ph[0] = t1_ph[i];
            run_cycle(oa, ea);
            check("t1_ack0", 32'(oa[0]), 32'd1);
            check("t1_tab_addr", 32'(tab_addr), 32'(t1_addr[i]));
        end
        req = '0;
        repeat (3) run_cycle(oa, ea);

        // Boundary phases: all-ones and quadrant-1 start.
        req   = 4'b0001;
        ph[0] = 10'h3FF;
        run_cycle(oa, ea);
        check("t2_addr_3ff", 32'(tab_addr), 32'h00);
        ph[0] = 10'h100;
        run_cycle(oa, ea);
        check("t2_addr_100", 32'(tab_addr), 32'hFF);
        ph[0] = 10'h000;
        run_cycle(oa, ea);
        check("t2_addr_000", 32'(tab_addr), 32'h00);
        req = '0;
        repeat (3) run_cycle(oa, ea);

        // Full contention out of reset: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) ph[i] = PW'($urandom);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            run_cycle(oa, ea);
            check("t3_rotate", 32'(oa), 32'(NREQ'(1) << (k % NREQ)));
            check("t3_onehot", 32'($onehot0(oa)), 32'd1);
        end
        req = '0;
        repeat (2) run_cycle(oa, ea);

        // Requesters 1 and 3 only: pointer must wrap past 3 back to 1.
        req = 4'b1000;
        run_cycle(oa, ea);
        check("t4_grant3", 32'(oa), 32'b1000);
        req = 4'b1010;
        run_cycle(oa, ea);
        check("t4_wrap1", 32'(oa), 32'b0010);
        run_cycle(oa, ea);
        check("t4_then3", 32'(oa), 32'b1000);
        run_cycle(oa, ea);
        check("t4_again1", 32'(oa), 32'b0010);
        req = '0;
        repeat (3) run_cycle(oa, ea);

        // Reset in the cycle after a grant discards the in-flight lookup.
        req   = 4'b0001;
        ph[0] = 10'h05A;
        run_cycle(oa, ea);
        req = '0;
        apply();
        #1 reset_n = 1'b0;
        #1;
        check("t5_async_addr", 32'(tab_addr), 32'd0);
        check("t5_async_valid", 32'(rsp_valid), 32'd0);
        check("t5_async_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("t5_hold_valid_a", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t5_hold_valid_b", 32'(rsp_valid), 32'd0);
        #2 reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        req   = 4'b0100;
        ph[2] = PW'($urandom);
        run_cycle(oa, ea);
        check("t5_grant2", 32'(oa), 32'b0100);
        req = '0;
        repeat (3) run_cycle(oa, ea);

        // Random traffic obeying the hold-while-unacked rule.
        for (int i = 0; i < NREQ; i++) begin
            m_ack_cnt[i] = 0;
            d_ack_cnt[i] = 0;
            d_rsp_cnt[i] = 0;
        end
        last_ea = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req[i] && !last_ea[i])) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    ph[i]  = PW'($urandom);
                end
            end
            run_cycle(oa, ea);
            last_ea = ea;
        end
        req = '0;
        repeat (3) run_cycle(oa, ea);
        for (int i = 0; i < NREQ; i++) begin
            check("cnt_rsp_vs_ack", 32'(d_rsp_cnt[i]), 32'(d_ack_cnt[i]));
            check("cnt_ack_vs_model", 32'(d_ack_cnt[i]), 32'(m_ack_cnt[i]));
        end
        check("queue_drained", 32'(m_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
